// File: rtl/ioshim_gpio_bank_if.sv
// rtl/ioshim_gpio_bank_if.sv - command/response bus for the GPIO bank shim
interface ioshim_gpio_bank_if;
  logic        io_en;
  logic [7:0]  io_dout1;
  logic [7:0]  io_dout2;
  logic [15:0] io_ab_dout;
  logic        io_wreg;
  logic        io_wa;
  logic        io_wb;
  logic [7:0]  io_din;
  logic [15:0] io_ab_din;

  modport master (
    output io_en, io_dout1, io_dout2, io_ab_dout,
    input  io_wreg, io_wa, io_wb, io_din, io_ab_din
  );

  modport slave (
    input  io_en, io_dout1, io_dout2, io_ab_dout,
    output io_wreg, io_wa, io_wb, io_din, io_ab_din
  );
endinterface

// File: rtl/ioshim_gpio_bank.sv
// rtl/ioshim_gpio_bank.sv - banked GPIO shim with edge interrupts behind a one-cycle command bus
module ioshim_gpio_bank #(
  parameter int NBANKS      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  ioshim_gpio_bank_if.slave   bus,
  output logic [8*NBANKS-1:0] gpio_dir,
  output logic [8*NBANKS-1:0] gpio_dout,
  input  logic [8*NBANKS-1:0] gpio_din,
  output logic                irq
);
  localparam int W = 8 * NBANKS;

  typedef enum logic [2:0] {
    OP_READ   = 3'd0,
    OP_WDIR   = 3'd1,
    OP_WOUT   = 3'd2,
    OP_SET    = 3'd3,
    OP_CLR    = 3'd4,
    OP_TGL    = 3'd5,
    OP_IRQCFG = 3'd6,
    OP_ACK    = 3'd7
  } op_e;

  logic [SYNC_STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0] sync_w, prev_q;
  logic [W-1:0] dir_q, dout_q, rise_q, fall_q, pend_q;
  logic [W-1:0] dir_d, dout_d, rise_d, fall_d, pend_d;
  logic [W-1:0] edge_set, ack_clr;

  op_e        op;
  logic [2:0] cmd_bank;
  logic       hit;
  logic [7:0] sel_sync, sel_dir, sel_dout, sel_rise, sel_fall, sel_pend;
  logic [7:0] rsp_din;
  logic [15:0] rsp_ab;
  logic       rsp_wab;
  logic       unused_ok;

  assign op        = op_e'(bus.io_dout1[7:5]);
  assign cmd_bank  = bus.io_dout1[2:0];
  assign unused_ok = ^{bus.io_dout1[4:3], bus.io_ab_dout[15:8]};

  assign sync_w    = sync_q[SYNC_STAGES-1];
  assign edge_set  = (sync_w & ~prev_q & rise_q) | (~sync_w & prev_q & fall_q);
  assign gpio_dir  = dir_q;
  assign gpio_dout = dout_q;

  // Pick out the addressed bank; an index past the last bank leaves hit low.
  always_comb begin
    hit      = 1'b0;
    sel_sync = '0;
    sel_dir  = '0;
    sel_dout = '0;
    sel_rise = '0;
    sel_fall = '0;
    sel_pend = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (cmd_bank == 3'(b)) begin
        hit      = 1'b1;
        sel_sync = sync_w[8*b +: 8];
        sel_dir  = dir_q[8*b +: 8];
        sel_dout = dout_q[8*b +: 8];
        sel_rise = rise_q[8*b +: 8];
        sel_fall = fall_q[8*b +: 8];
        sel_pend = pend_q[8*b +: 8];
      end
    end
  end

  // Next bank state; edge detection wins over an ACK of the same bit.
  always_comb begin
    dir_d   = dir_q;
    dout_d  = dout_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    ack_clr = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (bus.io_en && cmd_bank == 3'(b)) begin
        case (op)
          OP_WDIR:   dir_d[8*b +: 8]   = bus.io_dout2;
          OP_WOUT:   dout_d[8*b +: 8]  = bus.io_dout2;
          OP_SET:    dout_d[8*b +: 8]  = dout_q[8*b +: 8] | bus.io_dout2;
          OP_CLR:    dout_d[8*b +: 8]  = dout_q[8*b +: 8] & ~bus.io_dout2;
          OP_TGL:    dout_d[8*b +: 8]  = dout_q[8*b +: 8] ^ bus.io_dout2;
          OP_IRQCFG: begin
            rise_d[8*b +: 8] = bus.io_dout2;
            fall_d[8*b +: 8] = bus.io_ab_dout[7:0];
          end
          OP_ACK:    ack_clr[8*b +: 8] = bus.io_dout2;
          default:   ;
        endcase
      end
    end
    pend_d = (pend_q & ~ack_clr) | edge_set;
  end

  // Response payload from pre-update state; zero whenever there is no valid bank.
  always_comb begin
    rsp_din = '0;
    rsp_ab  = '0;
    rsp_wab = 1'b0;
    if (bus.io_en && hit) begin
      case (op)
        OP_READ: begin
          rsp_din = sel_sync;
          rsp_ab  = {sel_dir, sel_dout};
          rsp_wab = 1'b1;
        end
        OP_WDIR:                 rsp_din = sel_dir;
        OP_WOUT:                 rsp_din = sel_sync;
        OP_SET, OP_CLR, OP_TGL:  rsp_din = sel_dout;
        OP_IRQCFG: begin
          rsp_ab  = {sel_rise, sel_fall};
          rsp_wab = 1'b1;
        end
        OP_ACK:                  rsp_din = sel_pend;
        default:                 ;
      endcase
    end
  end

  // All state: synchroniser, bank registers, irq and the registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q        <= '0;
      prev_q        <= '0;
      dir_q         <= '0;
      dout_q        <= '0;
      rise_q        <= '0;
      fall_q        <= '0;
      pend_q        <= '0;
      irq           <= 1'b0;
      bus.io_wreg   <= 1'b0;
      bus.io_wa     <= 1'b0;
      bus.io_wb     <= 1'b0;
      bus.io_din    <= '0;
      bus.io_ab_din <= '0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], gpio_din};
      prev_q        <= sync_w;
      dir_q         <= dir_d;
      dout_q        <= dout_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      pend_q        <= pend_d;
      irq           <= |pend_q;
      bus.io_wreg   <= bus.io_en;
      bus.io_wa     <= rsp_wab;
      bus.io_wb     <= rsp_wab;
      bus.io_din    <= rsp_din;
      bus.io_ab_din <= rsp_ab;
    end
  end
endmodule

// File: doc/ioshim_gpio_bank.md
IOSHIM_GPIO_BANK -- requirements
Module: ioshim_gpio_bank

Interface
REQ-001 SHALL have parameter NBANKS, default 2, number of 8-bit GPIO banks (legal 1..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (legal 2..3).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port io_en  input  1  one-cycle command strobe.
REQ-006 SHALL have port io_dout1  input  8  command: [7:5] opcode, [4:3] ignored, [2:0] bank index.
REQ-007 SHALL have port io_dout2  input  8  command data byte.
REQ-008 SHALL have port io_ab_dout  input  16  auxiliary data; [7:0] used by opcode 6.
REQ-009 SHALL have ports io_wreg, io_wa, io_wb  output  1 each  registered write strobes for io_din, io_ab_din[7:0], io_ab_din[15:8].
REQ-010 SHALL have port io_din  output  8  response byte.
REQ-011 SHALL have port io_ab_din  output  16  auxiliary response.
REQ-012 SHALL have ports gpio_dir, gpio_dout  output  8*NBANKS  pin direction (1=drive) and output value; bank b at [8b+7:8b].
REQ-013 SHALL have port gpio_din  input  8*NBANKS  asynchronous pin inputs.
REQ-014 SHALL have port irq  output  1  registered OR of all pending bits.

Function
REQ-015 Every gpio_din bit SHALL pass through SYNC_STAGES flops; "sync" = last stage, "prev" = one flop after sync.
REQ-016 Responses SHALL appear exactly 1 cycle after io_en; io_din, io_ab_din, strobes SHALL be 0 in every cycle with no response.
REQ-017 io_wreg SHALL be 1 for every accepted command; io_wa/io_wb only where stated.
REQ-018 Opcode 0 READ: io_din = sync[bank]; io_ab_din = {dir[bank], dout[bank]}; io_wa = io_wb = 1.
REQ-019 Opcode 1 WDIR: dir[bank] <= io_dout2; io_din = previous dir[bank].
REQ-020 Opcode 2 WOUT: dout[bank] <= io_dout2; io_din = sync[bank].
REQ-021 Opcodes 3/4/5 SET/CLR/TGL: dout[bank] <= dout|data, dout&~data, dout^data; io_din = previous dout[bank].
REQ-022 Opcode 6 IRQCFG: rise_en[bank] <= io_dout2, fall_en[bank] <= io_ab_dout[7:0]; io_ab_din = previous {rise_en, fall_en}; io_wa = io_wb = 1; io_din = 0.
REQ-023 Opcode 7 ACK: pending[bank] &= ~io_dout2; io_din = pending[bank] before clear.
REQ-024 Per bit, pending SHALL set when (sync & ~prev & rise_en) | (~sync & prev & fall_en).
REQ-025 Edge set and ACK clear of same bit in same cycle: bit SHALL end set.
REQ-026 Disabling an enable SHALL NOT clear already-pending bits.
REQ-027 Bank index >= NBANKS: no state change; io_din = 0, io_ab_din = 0, io_wreg = 1, io_wa = io_wb = 0.
REQ-028 gpio_dir/gpio_dout SHALL be direct register outputs, updated the cycle after io_en.
REQ-029 irq SHALL equal OR of pending registered one cycle later (irq lags pending by 1 cycle).
REQ-030 Commands accepted every cycle back-to-back; each SHALL see state left by the previous command.

Reset
REQ-031 While reset=1 all registers SHALL be 0: dir, dout, rise_en, fall_en, pending, synchroniser, prev, irq, io_din, io_ab_din, io_wreg, io_wa, io_wb.
REQ-032 Reset SHALL take effect asynchronously, mid-command included; a command whose io_en coincides with reset release edge SHALL be ignored.
REQ-033 Pins high at reset release SHALL NOT set pending (enables are 0).

Verification
REQ-034 NBANKS=2: WDIR bank1 0xF0, then SET bank1 0x81 -> gpio_dir[15:8]=0xF0, gpio_dout[15:8]=0x81, second io_din=0x00, io_wreg pulses 1 cycle each.
REQ-035 gpio_din[3] 0->1 with rise_en[0]=0x08 -> pending[0]=0x08 after SYNC_STAGES+1 cycles, irq 1 cycle later; ACK 0x08 returns io_din=0x08, irq drops next cycle.
REQ-036 New rising edge on bit 3 in same cycle as ACK 0x08 -> pending stays 0x08, irq stays 1.
REQ-037 READ bank 5 with NBANKS=2 -> io_din=0, io_ab_din=0, io_wreg=1, io_wa=io_wb=0, no outputs change.
REQ-038 IRQCFG bank0 data 0x0F, ab 0x00F0, then IRQCFG 0 -> second io_ab_din=0x0FF0.
REQ-039 Assert reset mid back-to-back TGL stream -> all outputs 0 immediately, no strobe in first cycle after release.
